// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state type and the round/schedule mixing functions
// shared by the core and its message-schedule window.
package sha256_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUNDS, ST_FINAL} state_t;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] Ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] Maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] S0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] S1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_mem.sv
// 16-word message-schedule window: w[0] is always W_t for the current round,
// each advance shifts down and appends W_{t+16}.
module sha256_w_mem
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         advance,
  input  logic [511:0] block,
  output logic [31:0]  w_t
);

  logic [31:0] w [16];
  logic [31:0] w_new;

  // W_{t+16} = s1(W_{t+14}) + W_{t+9} + s0(W_{t+1}) + W_t
  assign w_new = s1(w[14]) + w[9] + s0(w[1]) + w[0];
  assign w_t   = w[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) w[i] <= block[511 - 32*i -: 32];
    end else if (advance) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
    end
  end

endmodule

// File: rtl/sha256_core.sv
// Iterative SHA-256 compression core: one round per clock, 66 cycles from
// accept to the digest_valid_o pulse.
module sha256_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         init_i,
  input  logic         next_i,
  input  logic [511:0] block_i,
  output logic         ready_o,
  output logic [255:0] digest_o,
  output logic         digest_valid_o
);

  state_t           state;
  logic [5:0]       t;
  logic [0:7][31:0] h_reg;
  logic [0:7][31:0] v;
  logic [31:0]      w_t, t1, t2;
  logic             accept;

  assign accept   = (state == ST_IDLE) && (init_i || next_i);
  assign digest_o = h_reg;
  assign t1 = v[7] + S1(v[4]) + Ch(v[4], v[5], v[6]) + K[t] + w_t;
  assign t2 = S0(v[0]) + Maj(v[0], v[1], v[2]);

  sha256_w_mem u_w_mem (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .advance (state == ST_ROUNDS),
    .block   (block_i),
    .w_t     (w_t)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      t              <= '0;
      h_reg          <= '0;
      v              <= '0;
      ready_o        <= 1'b1;
      digest_valid_o <= 1'b0;
    end else begin
      digest_valid_o <= 1'b0;
      case (state)
        ST_IDLE: if (init_i || next_i) begin
          state   <= ST_ROUNDS;
          ready_o <= 1'b0;
          t       <= '0;
          // init wins when both requests are raised together
          if (init_i) begin
            h_reg <= IV;
            v     <= IV;
          end else begin
            v     <= h_reg;
          end
        end
        ST_ROUNDS: begin
          v <= {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
          t <= t + 6'd1;
          if (t == 6'd63) state <= ST_FINAL;
        end
        ST_FINAL: begin
          for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + v[i];
          digest_valid_o <= 1'b1;
          ready_o        <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_core.sv
// Directed SHA-256 vectors; expected digests are queued at issue and checked
// by an independent monitor on every digest_valid_o pulse.
module tb_sha256_core;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         init_i = 1'b0;
  logic         next_i = 1'b0;
  logic [511:0] block_i = '0;
  logic         ready_o;
  logic [255:0] digest_o;
  logic         digest_valid_o;

  sha256_core dut (
    .clk            (clk),
    .rst            (rst),
    .init_i         (init_i),
    .next_i         (next_i),
    .block_i        (block_i),
    .ready_o        (ready_o),
    .digest_o       (digest_o),
    .digest_valid_o (digest_valid_o)
  );

  always #5 clk = ~clk;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {{15{32'h0}}, 32'h000001c0};

  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_MID   = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  int errors = 0;
  int checks = 0;
  logic [255:0] exp_q [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a request as soon as the core is ready; returns just after the accept edge.
  task automatic send(input logic [511:0] blk, input bit ini, input bit nxt);
    int n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {255'b0, ready_o}, 256'd1);
    block_i = blk;
    init_i  = ini;
    next_i  = nxt;
    @(posedge clk);
    #1;
    init_i  = 1'b0;
    next_i  = 1'b0;
    block_i = '0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!digest_valid_o && n < 200);
    check(name, {255'b0, digest_valid_o}, 256'd1);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  initial begin
    logic [255:0] e;
    forever begin
      @(negedge clk);
      if (rst && digest_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got digest %h expected no pulse", digest_o);
        end else begin
          e = exp_q.pop_front();
          check("digest", digest_o, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ready_lo, vld_bad;

    // reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {255'b0, ready_o}, 256'd1);
    check("rst_valid", {255'b0, digest_valid_o}, 256'd0);
    check("rst_digest", digest_o, 256'd0);
    rst = 1'b1;
    @(negedge clk);

    exp_q.push_back(D_ABC);
    send(BLK_ABC, 1'b1, 1'b0);
    wait_done("abc_done");

    exp_q.push_back(D_EMPTY);
    send(BLK_EMPTY, 1'b1, 1'b0);
    wait_done("empty_done");

    // two-block message, 2nd block issued in the pulse cycle of the 1st
    exp_q.push_back(D_MID);
    send(BLK_TWO1, 1'b1, 1'b0);
    wait_done("two_blk1_done");
    check("b2b_ready_at_pulse", {255'b0, ready_o}, 256'd1);
    exp_q.push_back(D_TWO);
    send(BLK_TWO2, 1'b0, 1'b1);
    wait_done("two_blk2_done");

    // timing: ready low exactly 65 cycles, stray requests at T+10 ignored
    exp_q.push_back(D_ABC);
    @(negedge clk);
    send(BLK_ABC, 1'b1, 1'b0);
    ready_lo = 0;
    vld_bad  = 0;
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      if (!ready_o) ready_lo++;
      if (k < 66 && digest_valid_o) vld_bad++;
      if (k == 10) begin
        init_i  = 1'b1;
        next_i  = 1'b1;
        block_i = BLK_EMPTY;
      end
      if (k == 11) begin
        init_i  = 1'b0;
        next_i  = 1'b0;
        block_i = '0;
      end
    end
    check("tim_ready_low_cycles", 256'(ready_lo), 256'd65);
    check("tim_early_valid", 256'(vld_bad), 256'd0);
    check("tim_valid_T66", {255'b0, digest_valid_o}, 256'd1);
    check("tim_ready_T66", {255'b0, ready_o}, 256'd1);
    @(negedge clk);
    check("tim_valid_T67", {255'b0, digest_valid_o}, 256'd0);
    check("tim_digest_hold", digest_o, D_ABC);
    @(negedge clk);
    check("tim_not_queued", {255'b0, ready_o}, 256'd1);

    // both requests high after an unrelated hash -> IV chaining
    exp_q.push_back(D_EMPTY);
    send(BLK_EMPTY, 1'b1, 1'b0);
    wait_done("pre_simul_done");
    exp_q.push_back(D_ABC);
    send(BLK_ABC, 1'b1, 1'b1);
    wait_done("simul_done");

    // reset in round t=30 abandons the block
    @(negedge clk);
    send(BLK_ABC, 1'b1, 1'b0);
    repeat (31) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mrst_ready", {255'b0, ready_o}, 256'd1);
    check("mrst_digest", digest_o, 256'd0);
    check("mrst_valid", {255'b0, digest_valid_o}, 256'd0);
    exp_q.push_back(D_ABC);
    send(BLK_ABC, 1'b1, 1'b0);
    wait_done("post_rst_abc_done");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 256'(exp_q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_core.md
SHA256_CORE -- requirements
Module: sha256_core

Interface
REQ-001 Parameters: none; the round count is fixed at 64.
REQ-002 clk  input  1  Single clock; all state changes on the rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-low: the block resets on a rising clk edge while rst=0.
REQ-004 init_i  input  1  Start of a new message: chain from the SHA-256 IV.
REQ-005 next_i  input  1  Continuation block: chain from the current H.
REQ-006 block_i  input  512  Padded 512-bit block; [511:480]=W0 ... [31:0]=W15, big-endian words.
REQ-007 ready_o  output  1  Core idle; init_i/next_i are accepted this cycle.
REQ-008 digest_o  output  256  H register; [255:224]=H0 ... [31:0]=H7.
REQ-009 digest_valid_o  output  1  One-cycle pulse: digest_o now holds the result of the last accepted block.

Function
REQ-010 Accept: a block is accepted in cycle T when ready_o=1 and (init_i or next_i); block_i is sampled in T only.
REQ-011 init_i and next_i both high at accept: treat as init.
REQ-012 init_i or next_i while ready_o=0: ignored, not queued.
REQ-013 State machine IDLE -> ROUNDS -> FINAL -> IDLE.
- IDLE: ready_o=1.
- On accept: go to ROUNDS; round counter t=0; W window loaded from block_i.
- On init accept: H:=IV and a..h:=IV.
- On next accept: a..h:=H.
REQ-014 ROUNDS: one compression round per cycle, t=0..63.
- W_t for t<16 comes from block_i.
- W_t for t>=16 = s1(W_t-2)+W_t-7+s0(W_t-15)+W_t-16, using a 16-word sliding window.
- Go to FINAL after t=63.
REQ-015 FINAL (one cycle): Hi := Hi + working var i for i=0..7; register digest_valid_o=1; go to IDLE.
REQ-016 All adds are 32-bit modulo 2^32; carries are discarded.
REQ-017 Timing for accept in cycle T:
- ready_o=0 in T+1..T+65.
- ready_o=1 and digest_valid_o=1 in T+66.
- digest_valid_o=0 thereafter until the next completion.
REQ-018 A new block may be accepted in the same cycle digest_valid_o pulses (T+66); back-to-back throughput is 1 block per 66 cycles.
REQ-019 digest_o changes only at FINAL, init accept, or reset; it holds otherwise, including across idle periods.
REQ-020 next_i after reset with no prior init: chains from H=0; this is defined behaviour, not an error.
REQ-021 digest_valid_o pulses after every block, including intermediate blocks; consumers filter by their own state.

Reset
REQ-022 While rst=0 at a clk edge: state=IDLE, t=0, H=0, a..h=0, W window=0, ready_o=1, digest_valid_o=0, digest_o=0.
REQ-023 Reset mid-ROUNDS or mid-FINAL: the block is abandoned and H is not updated; ready_o=1 in the first cycle after reset is released.
REQ-024 init_i/next_i presented in a cycle with rst=0: not accepted.

Structure
REQ-025 Shared package sha256_pkg holds:
- 64-entry K constant table.
- 8-word IV constant.
- state enum type.
- Functions Ch, Maj, S0, S1, s0, s1.
REQ-026 Sub-module sha256_w_mem holds the 16x32 W sliding window and W_t generation, with load/advance controls from sha256_core.
REQ-027 No multi-cycle paths: each round completes in one clock cycle.

Verification
REQ-028 "abc" test:
- Stimulus: init with block=61626380_0000...0000_00000018.
- Required response: digest_o=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad at the digest_valid_o pulse.
REQ-029 Empty-message test:
- Stimulus: init with block=80000000_0...0_00000000.
- Required response: digest_o=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-030 Two-block test:
- Stimulus: init with the 1st block of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", then next with the 2nd block (len 0x1c0), issued at the T+66 pulse of the 1st.
- Required response: final digest_o=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; intermediate pulse observed.
REQ-031 Timing test:
- Stimulus: accept at T; pulse init_i/next_i again in T+10.
- Required response: ready_o=0 for exactly 65 cycles; digest_valid_o high only at T+66; the extra requests are ignored and the digest is unchanged.
REQ-032 Simultaneous-request test:
- Stimulus: init_i=next_i=1 with the "abc" block, after a prior unrelated hash.
- Required response: the "abc" digest is produced, proving IV chaining.
REQ-033 Mid-operation reset test:
- Stimulus: rst=0 for one cycle at round t=30.
- Required response: next cycle ready_o=1, digest_o=0, digest_valid_o=0; a following "abc" run produces the correct digest.
